uart_rx: RTL and testbench

//   UART serial receiver; consumer of the baud_rate_gen sample tick (16x oversampling).
//   - Deserialises one start bit, DBIT data bits (LSB first), optional parity and a stop bit.
//   - Presents the received word on dout with a one-cycle completion strobe.
//   - Sits between the rx pad and the receive FIFO/interface logic.

---
 rtl/uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/(parity)/stop deserialiser.
// Ports: clk, reset (sync, active-high), rx (async serial line), s_tick
//   (16x baud pulse) -> rx_done_tick strobe, dout, frame_err, parity_err.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit after the
//   data bits (parameter PARITY_ODD selects odd parity, default even).
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err,
    output logic            parity_err
);

    localparam int         OVS    = 16;
    localparam logic [4:0] S_MID  = 5'(OVS / 2 - 1);
    localparam logic [4:0] S_LAST = 5'(OVS - 1);
    localparam logic [4:0] S_STOP = 5'(SB_TICK - 1);
    localparam logic [3:0] N_LAST = 4'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      s_q, s_d;
    logic [3:0]      n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            frame_err_q, frame_err_d;
    logic            done_q, done_d;
    logic            rx_meta_q, rx_meta_d;
    logic            rx_s_q, rx_s_d;
`ifdef UART_RX_PARITY_EN
    logic            par_bit_q, par_bit_d;
    logic            parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        b_d         = b_q;
        dout_d      = dout_q;
        frame_err_d = frame_err_q;
        done_d      = 1'b0;
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = parity_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Falling edge detection runs every clk, not only on s_tick.
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = 5'd0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        // Still low at the start-bit centre: a real frame.
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_d     = 5'd0;
                            n_d     = 4'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = 5'd0;
                        b_d = {rx_s_q, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 4'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d       = 5'd0;
                        par_bit_d = rx_s_q;
                        state_d   = STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        state_d     = IDLE;
                        dout_d      = b_q;
                        frame_err_d = ~rx_s_q;
                        done_d      = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = ((^b_q) ^ par_bit_q) != PARITY_ODD;
`endif
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            s_q         <= 5'd0;
            n_q         <= 4'd0;
            b_q         <= '0;
            dout_q      <= '0;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            dout_q      <= dout_d;
            frame_err_q <= frame_err_d;
            done_q      <= done_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_done_tick = done_q;
    assign dout         = dout_q;
    assign frame_err    = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = parity_err_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: normal, false-start, framing-error,
// back-to-back, reset-mid-frame and (with the macro) parity frames.
module tb_uart_rx;

    localparam int TICK_DIV = 5;
    localparam int BIT_CLK  = 16 * TICK_DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       s_tick = 1'b0;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;
    logic       parity_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int tick_cnt     = 0;
    int done_cnt     = 0;
    int wide_cnt     = 0;
    logic prev_done  = 1'b0;
    logic [7:0] last_dout;
    logic       last_fe;
    logic       last_pe;
    logic [7:0] dout_log [$];

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .frame_err    (frame_err),
        .parity_err   (parity_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        tick_cnt <= (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
        s_tick   <= (tick_cnt == TICK_DIV - 1);
    end

    always @(negedge clk) begin
        if (rx_done_tick) begin
            done_cnt++;
            last_dout = dout;
            last_fe   = frame_err;
            last_pe   = parity_err;
            dout_log.push_back(dout);
            if (prev_done) wide_cnt++;
        end
        prev_done = rx_done_tick;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic val, input int ticks);
        rx = val;
        repeat (ticks * TICK_DIV) @(negedge clk);
    endtask

    // stop_ticks < 16 shortens a low stop bit so the line is back high
    // before the receiver's false-start check.
    task automatic send_frame(input logic [7:0] d, input logic stop_val,
                              input logic par_flip, input int stop_ticks);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip, 16);
`endif
        send_bit(stop_val, stop_ticks);
        rx = 1'b1;
    endtask

    task automatic idle(input int bits);
        rx = 1'b1;
        repeat (bits * BIT_CLK) @(negedge clk);
    endtask

    int base;

    initial begin
        rx    = 1'b1;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_done", {31'd0, rx_done_tick}, 32'd0);
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_perr", {31'd0, parity_err}, 32'd0);
        reset = 1'b0;
        idle(1);

        base = done_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, 16);
        idle(2);
        check("a5_cnt", done_cnt - base, 32'd1);
        check("a5_dout", {24'd0, last_dout}, 32'hA5);
        check("a5_ferr", {31'd0, last_fe}, 32'd0);
        check("a5_perr", {31'd0, last_pe}, 32'd0);

        base = done_cnt;
        send_bit(1'b0, 4);
        idle(3);
        check("glitch_cnt", done_cnt - base, 32'd0);
        check("glitch_dout", {24'd0, dout}, 32'hA5);

        base = done_cnt;
        send_frame(8'h00, 1'b0, 1'b0, 11);
        idle(3);
        check("brk_cnt", done_cnt - base, 32'd1);
        check("brk_dout", {24'd0, last_dout}, 32'h00);
        check("brk_ferr", {31'd0, last_fe}, 32'd1);
        check("brk_hold", {31'd0, frame_err}, 32'd1);

        base = done_cnt;
        dout_log.delete();
        send_frame(8'h55, 1'b1, 1'b0, 16);
        send_frame(8'hFF, 1'b1, 1'b0, 16);
        idle(2);
        check("b2b_cnt", done_cnt - base, 32'd2);
        check("b2b_first", {24'd0, (dout_log.size() > 0) ? dout_log[0] : 8'hEE}, 32'h55);
        check("b2b_second", {24'd0, (dout_log.size() > 1) ? dout_log[1] : 8'hEE}, 32'hFF);
        check("b2b_ferr", {31'd0, frame_err}, 32'd0);

        base = done_cnt;
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b0, 16);
        send_bit(1'b0, 16);
        send_bit(1'b0, 8);
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_dout", {24'd0, dout}, 32'd0);
        check("rstmid_ferr", {31'd0, frame_err}, 32'd0);
        idle(12);
        check("rstmid_cnt", done_cnt - base, 32'd0);
        check("rstmid_dout2", {24'd0, dout}, 32'd0);
        base = done_cnt;
        send_frame(8'h3C, 1'b1, 1'b0, 16);
        idle(2);
        check("after_cnt", done_cnt - base, 32'd1);
        check("after_dout", {24'd0, last_dout}, 32'h3C);

`ifdef UART_RX_PARITY_EN
        base = done_cnt;
        send_frame(8'h07, 1'b1, 1'b0, 16);
        idle(2);
        check("par_ok_cnt", done_cnt - base, 32'd1);
        check("par_ok_dout", {24'd0, last_dout}, 32'h07);
        check("par_ok_perr", {31'd0, last_pe}, 32'd0);
        base = done_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 16);
        idle(2);
        check("par_bad_cnt", done_cnt - base, 32'd1);
        check("par_bad_perr", {31'd0, last_pe}, 32'd1);
`endif

        check("strobe_width", wide_cnt, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
